// File: rtl/rvfi_eot_monitor.sv
// rvfi_eot_monitor
// Turns the RVFI tracer's end-of-test word into a registered termination
// status (done / pass / fail / timeout, exit code, cycle stamp). A drain
// window delays done_o so trailing trace output settles, and the status is
// held until the bench acknowledges it.
//
// Optional build macro: RVFI_EOT_SIM_FINISH_EN
//   defined   -> prints one status line on entering DONE and calls $finish
//                one edge later (simulation only)
//   undefined -> pure handshake behaviour, synthesizable
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for an end-of-test event (word bit0 = 1)
// DRAIN  | event captured, counting down the drain window
// DONE   | status valid on the outputs, waiting for ack_i

module rvfi_eot_monitor #(
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter int unsigned CNT_W        = 32,
  parameter logic [7:0]  HART_ID      = 8'h00
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      end_of_test_i,
  input  logic             ack_i,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [30:0]      exit_code_o,
  output logic [CNT_W-1:0] cycle_stamp_o,
  output logic             busy_o
);

  localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0] DRN_LOAD =
    (DRAIN_CYCLES == 0) ? '0 : DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [DRN_W-1:0] DRN_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cyc_cnt;
  logic [DRN_W-1:0]   drain_cnt;

  logic [30:0]        cap_exit;
  logic [CNT_W-1:0]   cap_stamp;
  logic               cap_pass;
  logic               cap_fail;
  logic               cap_timeout;

  logic               word_timeout;
  logic               word_pass;
  logic               capture;
  logic               release_done;

  // Classification of the incoming word; timeout takes priority over pass.
  assign word_timeout = (end_of_test_i == 32'hFFFF_FFFF);
  assign word_pass    = (end_of_test_i == 32'h0000_0001);
  assign capture      = (state == S_IDLE) && end_of_test_i[0];
  assign release_done = (state == S_DONE) && ack_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; only the first event is taken, later words are ignored
  // until the bench releases the status.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (end_of_test_i[0]) begin
          if (DRAIN_CYCLES == 0) begin
            state_next = S_DONE;
          end else begin
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (ack_i) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic; flags and status are visible only while done.
  always_comb begin
    done_o        = 1'b0;
    busy_o        = 1'b0;
    pass_o        = 1'b0;
    fail_o        = 1'b0;
    timeout_o     = 1'b0;
    exit_code_o   = '0;
    cycle_stamp_o = '0;
    case (state)
      S_DRAIN: begin
        busy_o = 1'b1;
      end
      S_DONE: begin
        busy_o        = 1'b1;
        done_o        = 1'b1;
        pass_o        = cap_pass;
        fail_o        = cap_fail;
        timeout_o     = cap_timeout;
        exit_code_o   = cap_exit;
        cycle_stamp_o = cap_stamp;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // Free-running cycle counter, saturating at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_cnt <= '0;
    end else if (cyc_cnt != '1) begin
      cyc_cnt <= cyc_cnt + CNT_ONE;
    end
  end

  // Drain down-counter: loaded on capture, terminal count at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drain_cnt <= '0;
    end else if (capture) begin
      drain_cnt <= DRN_LOAD;
    end else if ((state == S_DRAIN) && (drain_cnt != '0)) begin
      drain_cnt <= drain_cnt - DRN_ONE;
    end
  end

  // Status registers: written on capture, cleared when the bench acks.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_exit    <= '0;
      cap_stamp   <= '0;
      cap_pass    <= 1'b0;
      cap_fail    <= 1'b0;
      cap_timeout <= 1'b0;
    end else if (capture) begin
      cap_exit    <= end_of_test_i[31:1];
      cap_stamp   <= cyc_cnt;
      cap_timeout <= word_timeout;
      cap_pass    <= !word_timeout && word_pass;
      cap_fail    <= !word_timeout && !word_pass;
    end else if (release_done) begin
      cap_exit    <= '0;
      cap_stamp   <= '0;
      cap_pass    <= 1'b0;
      cap_fail    <= 1'b0;
      cap_timeout <= 1'b0;
    end
  end

`ifdef RVFI_EOT_SIM_FINISH_EN
  logic             finish_pend;
  logic             msg_pass;
  logic             msg_timeout;
  logic [30:0]      msg_exit;
  logic [CNT_W-1:0] msg_stamp;

  // With zero drain the registers load on the same edge DONE is entered,
  // so the message takes the live word in that case.
  assign msg_pass    = capture ? (!word_timeout && word_pass) : cap_pass;
  assign msg_timeout = capture ? word_timeout : cap_timeout;
  assign msg_exit    = capture ? end_of_test_i[31:1] : cap_exit;
  assign msg_stamp   = capture ? cyc_cnt : cap_stamp;

  // Announce the result on entry to DONE, end the simulation one edge later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      finish_pend <= 1'b0;
    end else begin
      if (finish_pend) begin
        $finish;
      end
      if ((state != S_DONE) && (state_next == S_DONE)) begin
        $display("rvfi_eot_monitor hart %0d: %s exit_code=%0d cycle=%0d",
                 HART_ID,
                 msg_timeout ? "TIMEOUT" : (msg_pass ? "PASS" : "FAIL"),
                 msg_exit, msg_stamp);
        finish_pend <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/rvfi_eot_monitor.md
Name: rvfi_eot_monitor

Overview:
- Sits directly downstream of the per-hart RVFI tracer.
- Consumes its 32-bit end-of-test word and turns it into a clean, registered termination status for the testbench top: done, pass, fail, timeout, exit code and cycle stamp.
- Adds a drain window so trailing trace output and memory writes settle before done is raised.
- Holds status until the bench acknowledges it.

Parameters:
- DRAIN_CYCLES, 16, clocks between capture of the end-of-test event and done_o rising; 0 is legal.
- CNT_W, 32, width of the free-running cycle counter and the cycle stamp.
- HART_ID, 8'h00, hart index; used only in the optional finish message.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- end_of_test_i  in  32  end-of-test word from tracer; bit0=1 marks an event
- ack_i  in  1  bench acknowledge; honoured only in DONE
- done_o  out  1  status valid
- pass_o  out  1  captured word == 32'h0000_0001
- fail_o  out  1  captured word bit0=1, not 1, not all-ones
- timeout_o  out  1  captured word == 32'hFFFF_FFFF
- exit_code_o  out  31  captured word[31:1]
- cycle_stamp_o  out  CNT_W  cycle counter value at capture
- busy_o  out  1  state is DRAIN or DONE

Behaviour:
- One clock domain. Reset is asynchronous, active-low, on rst_ni; all state is async-cleared.
- Reset values: state=IDLE; all outputs 0; cycle counter 0; drain counter 0.
- Cycle counter: +1 every clock out of reset; saturates at all-ones (no wrap).
- Classification is decided once, at capture, in this priority order:
  - word==32'hFFFF_FFFF -> timeout
  - word==32'h1 -> pass
  - otherwise fail
- Exactly one of pass_o/fail_o/timeout_o is 1 while done_o=1; all three are 0 otherwise.
- State machine IDLE / DRAIN / DONE:
  - IDLE: at an edge with end_of_test_i[0]=1, capture word[31:1], classification and cycle counter into registers.
    - If DRAIN_CYCLES=0, go to DONE.
    - Otherwise go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
  - DRAIN: if drain counter==0, go to DONE; else decrement.
    - end_of_test_i is ignored: first event wins, including a later timeout word.
  - DONE: done_o=1 and status outputs drive the captured values.
    - Remain in DONE until ack_i=1 is sampled; then go to IDLE and clear done/pass/fail/timeout/exit_code/cycle_stamp on the same edge.
- Latency: event sampled at edge k -> done_o=1 after edge k+DRAIN_CYCLES.
- ack_i outside DONE has no effect.
- end_of_test_i with bit0=0 never triggers a capture, whatever the upper bits.
- Event present on the same edge that ack_i is sampled in DONE: it is not captured. The monitor needs one IDLE cycle; the tracer holds the word, so the event is taken on the next edge.
- Reset asserted mid-DRAIN or in DONE: immediate return to IDLE with all outputs at reset values; the captured event is lost.
- Status registers are written only on capture; they are stable throughout DRAIN and DONE.

Optional Feature:
- Macro RVFI_EOT_SIM_FINISH_EN.
- Defined: on the edge entering DONE, $display one line with HART_ID, PASS/FAIL/TIMEOUT, exit code in decimal and cycle stamp; then call $finish on the following edge. ack_i is irrelevant in this mode.
- Undefined: no display and no $finish; purely the handshake behaviour above. This is the synthesizable, emulation-safe form.

Test Plan:
- DRAIN_CYCLES=16, end_of_test_i=32'h1 at edge 100 after reset release -> done_o rises after edge 116; pass_o=1, exit_code_o=0, cycle_stamp_o=100, busy_o=1 from edge 100.
- end_of_test_i=32'h0000_0007 -> fail_o=1, exit_code_o=3, pass_o=timeout_o=0.
- end_of_test_i=32'hFFFF_FFFF -> timeout_o=1, fail_o=0, exit_code_o=31'h7FFF_FFFF.
- Word 32'h5 captured, then 32'hFFFF_FFFF presented during DRAIN -> final status fail_o=1, exit_code_o=2; hold done_o 10 cycles, pulse ack_i -> all outputs 0 after that edge, state IDLE.
- DRAIN_CYCLES=0, word 32'h1 at edge k -> done_o=1 after edge k. Separately, reset pulsed 3 cycles into DRAIN -> done_o never rises, outputs 0.
- end_of_test_i=32'hFFFF_FFFE (bit0=0) held 50 cycles -> no capture, busy_o=0. With RVFI_EOT_SIM_FINISH_EN defined, word 32'h1 -> one PASS line printed and simulation ends one edge after done_o rises.
